// File: rtl/vga_timing_receiver.sv
// Sink end of the VGA link: recovers beam column/row from the sync edges, checks the timing
// and emits an x/y-tagged pixel stream with lock and error status.
//
// state  | meaning
// SEARCH | waiting for the first hsync rise, line counter cleared
// HTRACK | column aligned, counting good lines until armed, waiting for vsync rise
// LOCKED | full frame alignment, visible pixels flagged valid
module vga_timing_receiver #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FPORCH   = 16,
  parameter int H_PULSE    = 96,
  parameter int H_MAX      = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_MAX      = 525,
  parameter int V_RISE_ROW = 491,
  parameter int LOCK_LINES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [8:0] rgb,
  output logic       pix_valid,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic [8:0] out_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_RISE_COL = 10'(H_ACTIVE + H_FPORCH + H_PULSE);
  localparam logic [9:0] H_LAST     = 10'(H_MAX - 1);
  localparam logic [9:0] V_LAST     = 10'(V_MAX - 1);
  localparam logic [9:0] V_RISE     = 10'(V_RISE_ROW);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_LINES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HTRACK = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       hs_q, hs_d, vs_q, vs_d;
  logic [9:0] col_q, col_d, row_q, row_d;
  logic [3:0] good_q, good_d;
  logic       armed_q, armed_d;
  logic       seen_h_q, seen_h_d, seen_v_q, seen_v_d;
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic [8:0] out_rgb_q, out_rgb_d;
  logic       frame_start_q, frame_start_d;
  logic       locked_q, locked_d;
  logic       timing_err_q, timing_err_d;
  logic [7:0] err_count_q, err_count_d;

  logic       hrise, vrise, h_ok, v_ok;
  logic       col_wrap, row_wrap, miss_h, miss_v;
  logic [9:0] col_free, col_n, row_free, row_n;

  always_comb begin
    hrise    = hsync & ~hs_q;
    vrise    = vsync & ~vs_q;
    col_free = (col_q == H_LAST) ? 10'd0 : col_q + 10'd1;
    col_n    = hrise ? H_RISE_COL : col_free;
    col_wrap = (col_q == H_LAST) && !hrise;
    h_ok     = (col_q + 10'd1) == H_RISE_COL;
    row_free = row_q;
    if (col_wrap) begin
      row_free = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
    end
    row_wrap = col_wrap && (row_q == V_LAST);
    row_n    = vrise ? V_RISE : row_free;
    v_ok     = (row_free == V_RISE);
    // A wrap with no sync rise since the previous wrap means the sync pulse went missing
    miss_h   = col_wrap && !seen_h_q;
    miss_v   = row_wrap && !vrise && !seen_v_q;
    seen_h_d = hrise | (seen_h_q & ~col_wrap);
    seen_v_d = vrise | (seen_v_q & ~row_wrap);

    hs_d    = hsync;
    vs_d    = vsync;
    col_d   = col_n;
    row_d   = row_n;
    state_d = state_q;
    good_d  = good_q;
    timing_err_d = 1'b0;

    unique case (state_q)
      SEARCH: begin
        good_d = 4'd0;
        if (hrise) state_d = HTRACK;
      end
      HTRACK: begin
        if (hrise && !h_ok) begin
          timing_err_d = 1'b1;
          state_d      = SEARCH;
        end else begin
          if (hrise && good_q < LOCK_CNT) good_d = good_q + 4'd1;
          if (vrise && armed_q) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if ((hrise && !h_ok) || (vrise && !v_ok) || miss_h || miss_v) begin
          timing_err_d = 1'b1;
          state_d      = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase

    armed_d       = (good_d >= LOCK_CNT);
    locked_d      = (state_q == LOCKED);
    pix_valid_d   = (state_q == LOCKED) && !timing_err_d && (col_n < H_VIS) && (row_n < V_VIS);
    frame_start_d = pix_valid_d && (col_n == 10'd0) && (row_n == 10'd0);
    out_x_d       = col_n;
    out_y_d       = row_n;
    out_rgb_d     = rgb;
    err_count_d   = err_count_q;
    if (timing_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      col_q         <= 10'd0;
      row_q         <= 10'd0;
      good_q        <= 4'd0;
      armed_q       <= 1'b0;
      seen_h_q      <= 1'b0;
      seen_v_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      out_x_q       <= 10'd0;
      out_y_q       <= 10'd0;
      out_rgb_q     <= 9'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
      err_count_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      col_q         <= col_d;
      row_q         <= row_d;
      good_q        <= good_d;
      armed_q       <= armed_d;
      seen_h_q      <= seen_h_d;
      seen_v_q      <= seen_v_d;
      pix_valid_q   <= pix_valid_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_rgb_q     <= out_rgb_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_rgb     = out_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver on a shrunken raster: a source generator with fault knobs,
// a per-cycle expectation queue, a pixel probe table and hand-checked sync-fault sequences.
module tb_vga_timing_receiver;

  localparam int HA = 16, HF = 2, HP = 4, HM = 24;
  localparam int VA = 10, VM = 16, VR = 13, LL = 4;
  localparam int HR = HA + HF + HP;
  localparam int FRAME = HM * VM;

  logic       clock = 1'b0;
  logic       reset, hsync, vsync;
  logic [8:0] rgb;
  logic       pix_valid, frame_start, locked, timing_err;
  logic [9:0] out_x, out_y;
  logic [8:0] out_rgb;
  logic [7:0] err_count;

  always #5 clock = ~clock;

  vga_timing_receiver #(
    .H_ACTIVE(HA), .H_FPORCH(HF), .H_PULSE(HP), .H_MAX(HM),
    .V_ACTIVE(VA), .V_MAX(VM), .V_RISE_ROW(VR), .LOCK_LINES(LL)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .out_x(out_x), .out_y(out_y), .out_rgb(out_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .err_count(err_count)
  );

  typedef struct {
    logic       pv, fs, lk, er;
    int         cnt;
    logic       chk_x, chk_y;
    int         x, y;
    logic [8:0] rgb;
  } exp_t;

  typedef struct {
    int         col, row;
    logic [8:0] rgb;
    logic       pv, fs;
  } probe_t;

  exp_t sb_q[$];
  int   n_pass = 0, n_total = 0;

  // source generator state and fault knobs
  int         scol, srow;
  bit         skip_pending, vs_kill, rgb_hold;
  logic       rst_drive;
  logic [8:0] rgb_drive;

  // expectation model, written in terms of the source raster
  int m_state, m_good, m_cnt, m_since_h;
  bit m_prev_hs, m_prev_vs, m_vseen, m_h_al, m_v_al;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t (src col %0d row %0d)",
                  name, act, exp, $time, scol, srow);
  endtask

  task automatic step();
    logic hs, vs, hr, vr;
    exp_t e;
    exp_t o;
    int   cur, nxt, good_pre;
    bit   err;
    hs = !(scol >= HA + HF && scol < HR);
    vs = vs_kill || !(srow >= VR - 2 && srow < VR);
    if (!rgb_hold) rgb_drive = 9'($urandom_range(0, 511));
    hsync = hs; vsync = vs; rgb = rgb_drive; reset = rst_drive;
    e = '{pv:0, fs:0, lk:0, er:0, cnt:0, chk_x:1, chk_y:1, x:0, y:0, rgb:9'd0};
    if (!rst_drive) begin
      m_state = 0; m_good = 0; m_cnt = 0; m_since_h = 0;
      m_vseen = 0; m_h_al = 0; m_v_al = 0;
      m_prev_hs = 1; m_prev_vs = 1;
    end else begin
      hr = hs && !m_prev_hs;
      vr = vs && !m_prev_vs;
      cur = m_state; nxt = cur; err = 0;
      if (cur == 0) m_good = 0;
      good_pre = m_good;
      if (hr) begin
        if (cur == 0) nxt = 1;
        else if (m_since_h != HM - 1) begin err = 1; nxt = 0; end
        else if (cur == 1 && m_good < LL) m_good++;
        m_since_h = 0; m_h_al = 1;
      end else m_since_h++;
      if (vr) begin
        if (cur == 1 && good_pre >= LL && !err) nxt = 2;
        else if (cur == 2 && srow != VR) begin err = 1; nxt = 0; end
        m_vseen = 1; m_v_al = 1;
      end else if (scol == 0 && srow == 0) begin
        if (cur == 2 && !m_vseen) begin err = 1; nxt = 0; end
        m_vseen = 0;
      end
      m_state = nxt;
      if (err && m_cnt < 255) m_cnt++;
      e.lk = (cur == 2); e.er = err; e.cnt = m_cnt;
      e.pv = (cur == 2) && !err && scol < HA && srow < VA;
      e.fs = e.pv && scol == 0 && srow == 0;
      e.x = scol; e.y = srow; e.rgb = rgb_drive;
      e.chk_x = m_h_al; e.chk_y = m_v_al;
      m_prev_hs = hs; m_prev_vs = vs;
    end
    sb_q.push_back(e);
    if (skip_pending && scol == HR - 2) begin scol = HR; skip_pending = 0; end
    else if (scol == HM - 1) begin scol = 0; srow = (srow == VM - 1) ? 0 : srow + 1; end
    else scol++;
    @(posedge clock);
    #1;
    o = sb_q.pop_front();
    chk("pix_valid", int'(pix_valid), int'(o.pv));
    chk("frame_start", int'(frame_start), int'(o.fs));
    chk("locked", int'(locked), int'(o.lk));
    chk("timing_err", int'(timing_err), int'(o.er));
    chk("err_count", int'(err_count), o.cnt);
    chk("out_rgb", int'(out_rgb), int'(o.rgb));
    if (o.chk_x) chk("out_x", int'(out_x), o.x);
    if (o.chk_y) chk("out_y", int'(out_y), o.y);
  endtask

  task automatic run_to(input int c, input int r);
    int n;
    n = 0;
    while (!(scol == c && srow == r) && n < 2 * FRAME) begin step(); n++; end
    chk("run_to_reached", int'(scol == c && srow == r), 1);
  endtask

  probe_t probes[5];
  int     lock_at, last_fs, n_fs, n_pv, n_err, err_at, relock;
  bit     saw_unlock;

  initial begin
    probes[0] = '{col:0,  row:0,  rgb:9'h0AA, pv:1'b1, fs:1'b1};
    probes[1] = '{col:5,  row:3,  rgb:9'h1FC, pv:1'b1, fs:1'b0};
    probes[2] = '{col:16, row:3,  rgb:9'h1FF, pv:1'b0, fs:1'b0};
    probes[3] = '{col:15, row:9,  rgb:9'h155, pv:1'b1, fs:1'b0};
    probes[4] = '{col:5,  row:10, rgb:9'h0F0, pv:1'b0, fs:1'b0};

    skip_pending = 0; vs_kill = 0; rgb_hold = 0; rgb_drive = 9'd0;
    reset = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 9'd0;

    // reset held while hsync toggles and vsync sits low
    rst_drive = 1'b0; scol = 17; srow = 11;
    repeat (3) step();
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);

    // ideal source from the top of frame: lock latency, frame period, pixel count
    scol = 0; srow = 0; rst_drive = 1'b1;
    lock_at = -1; last_fs = -1; n_fs = 0; n_pv = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (locked && lock_at < 0) lock_at = i;
      if (i >= FRAME) begin
        if (pix_valid) n_pv++;
        if (frame_start) begin
          n_fs++;
          if (last_fs >= 0) chk("frame_period", i - last_fs, FRAME);
          last_fs = i;
        end
      end
    end
    chk("lock_latency", lock_at, VR * HM + 1);
    chk("frame_start_count", n_fs, 2);
    chk("pix_valid_count", n_pv, 2 * HA * VA);

    // pixel probes inside a locked frame
    for (int p = 0; p < 5; p++) begin
      run_to(probes[p].col, probes[p].row);
      rgb_hold = 1; rgb_drive = probes[p].rgb;
      step();
      rgb_hold = 0;
      chk("probe_pix_valid", int'(pix_valid), int'(probes[p].pv));
      chk("probe_frame_start", int'(frame_start), int'(probes[p].fs));
      chk("probe_out_x", int'(out_x), probes[p].col);
      chk("probe_out_y", int'(out_y), probes[p].row);
      chk("probe_out_rgb", int'(out_rgb), int'(probes[p].rgb));
    end

    // one 23-column line in row 5, then relock at the vsync rise of the same frame
    run_to(0, 5);
    skip_pending = 1; n_err = 0; relock = -1; saw_unlock = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (timing_err) n_err++;
      if (!locked) saw_unlock = 1;
      if (saw_unlock && locked && relock < 0) relock = i;
    end
    chk("short_line_err_pulses", n_err, 1);
    chk("short_line_err_count", int'(err_count), 1);
    chk("short_line_unlocked", int'(saw_unlock), 1);
    chk("short_line_relock_at", relock, (HM - 1) + (VR - 6) * HM + 1);

    // one frame without vsync: error at the next frame top, no pixels until relock
    run_to(0, 0);
    vs_kill = 1;
    step();
    run_to(0, 0);
    vs_kill = 0;
    n_err = 0; err_at = -1; n_pv = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (timing_err) begin n_err++; if (err_at < 0) err_at = i; end
      if (pix_valid) n_pv++;
    end
    chk("no_vsync_err_pulses", n_err, 1);
    chk("no_vsync_err_at", err_at, 0);
    chk("no_vsync_pix_valid", n_pv, 0);
    chk("no_vsync_err_count", int'(err_count), 2);
    chk("no_vsync_relocked", int'(locked), 1);

    // single-cycle reset mid-frame while locked
    run_to(7, 5);
    rst_drive = 1'b0;
    step();
    rst_drive = 1'b1;
    chk("midrst_pix_valid", int'(pix_valid), 0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_err_count", int'(err_count), 0);
    chk("midrst_out_x", int'(out_x), 0);
    chk("midrst_out_rgb", int'(out_rgb), 0);
    relock = -1;
    for (int i = 0; i < 2 * FRAME && relock < 0; i++) begin
      step();
      if (locked) relock = i;
    end
    chk("midrst_relock_at", relock, (HM - 8) + (VR - 6) * HM + 1);
    repeat (HM * 4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
